// File: rtl/nn_pkg.sv
// Shared types and helpers for the kernel classifier: FSM states,
// accumulator sizing and score clamping.
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        EMIT = 2'd2
    } nn_state_e;

    // Full-precision width: product of two PIX_W values summed NPIX times, plus sign.
    function automatic int nn_acc_width(input int npix, input int pix_w);
        return 2 * pix_w + $clog2(npix) + 1;
    endfunction

    // Index width that never collapses to zero bits when a count is 1.
    function automatic int nn_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [63:0] nn_saturate(input logic signed [63:0] v,
                                                        input int                 out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Signed multiply-accumulate with synchronous clear; the accumulator is wide
// enough that a full kernel dot-product never overflows.
module nn_mac_unit #(
    parameter int PIX_W = 8,
    parameter int ACC_W = 21
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [PIX_W-1:0] a_i,
    input  logic signed [PIX_W-1:0] b_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [2*PIX_W-1:0] a_ext;
    logic signed [2*PIX_W-1:0] b_ext;
    logic signed [2*PIX_W-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_d;

    assign a_ext    = {{PIX_W{a_i[PIX_W-1]}}, a_i};
    assign b_ext    = {{PIX_W{b_i[PIX_W-1]}}, b_i};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(ACC_W-2*PIX_W){prod[2*PIX_W-1]}}, prod};

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_o_sel(acc_q);

    function automatic logic signed [ACC_W-1:0] acc_o_sel(input logic signed [ACC_W-1:0] v);
        return v;
    endfunction

endmodule

// File: rtl/nn_kernel_classifier.sv
// Programmable-kernel image classifier: serial MAC per kernel, one score beat
// per kernel, argmax class on the last beat. Define NN_SAT_EN to clamp scores.
module nn_kernel_classifier
    import nn_pkg::*;
#(
    parameter  int NPIX  = 9,
    parameter  int PIX_W = 8,
    parameter  int NKERN = 4,
    parameter  int OUT_W = 8,
    localparam int KW    = nn_idx_width(NKERN),
    localparam int PW    = nn_idx_width(NPIX),
    localparam int ACC_W = nn_acc_width(NPIX, PIX_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    w_wr,
    input  logic [KW-1:0]           w_kern,
    input  logic [PW-1:0]           w_pix,
    input  logic [PIX_W-1:0]        w_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NPIX*PIX_W-1:0]   in_image,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_score,
    output logic [KW-1:0]           out_kern,
    output logic                    out_last,
    output logic [KW-1:0]           out_class
);

    nn_state_e               state_q, state_d;
    logic [KW-1:0]           kern_q, kern_d;
    logic [PW-1:0]           pix_q, pix_d;
    logic signed [ACC_W-1:0] best_val_q, best_val_d;
    logic [KW-1:0]           best_idx_q, best_idx_d;
    logic [NPIX*PIX_W-1:0]   img_q;
    logic signed [PIX_W-1:0] w_q [NKERN][NPIX];
    logic signed [PIX_W-1:0] img_pix [NPIX];

    logic                    accept;
    logic                    wr_ok;
    logic                    last_kern;
    logic                    mac_clr;
    logic                    mac_en;
    logic signed [PIX_W-1:0] mac_a;
    logic signed [PIX_W-1:0] mac_b;
    logic signed [ACC_W-1:0] acc;
    logic [KW-1:0]           class_sel;

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign last_kern = (kern_q == KW'(NKERN - 1));

    // Writes are only legal while idle, so a write in the accept cycle is seen by that image.
    assign wr_ok = w_wr && in_ready && (32'(w_kern) < NKERN) && (32'(w_pix) < NPIX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NKERN; k++) begin
                for (int p = 0; p < NPIX; p++) begin
                    w_q[k][p] <= '0;
                end
            end
        end else if (wr_ok) begin
            w_q[w_kern][w_pix] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_q <= '0;
        end else if (accept) begin
            img_q <= in_image;
        end
    end

    always_comb begin
        for (int p = 0; p < NPIX; p++) begin
            img_pix[p] = img_q[p*PIX_W +: PIX_W];
        end
    end

    assign mac_a = img_pix[pix_q];
    assign mac_b = w_q[kern_q][pix_q];

    nn_mac_unit #(
        .PIX_W (PIX_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (mac_a),
        .b_i   (mac_b),
        .acc_o (acc)
    );

    always_comb begin
        state_d    = state_q;
        kern_d     = kern_q;
        pix_d      = pix_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = MAC;
                    kern_d  = '0;
                    pix_d   = '0;
                    mac_clr = 1'b1;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (pix_q == PW'(NPIX - 1)) begin
                    state_d = EMIT;
                end else begin
                    pix_d = pix_q + PW'(1);
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (last_kern) begin
                        state_d = IDLE;
                    end else begin
                        state_d = MAC;
                        kern_d  = kern_q + KW'(1);
                        pix_d   = '0;
                        mac_clr = 1'b1;
                        // Strict compare keeps the lowest index on ties.
                        if ((kern_q == '0) || (acc > best_val_q)) begin
                            best_val_d = acc;
                            best_idx_d = kern_q;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            kern_q     <= '0;
            pix_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            kern_q     <= kern_d;
            pix_q      <= pix_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign out_valid = (state_q == EMIT);
    assign out_last  = out_valid && last_kern;
    assign out_kern  = kern_q;
    assign class_sel = ((kern_q != '0) && (acc > best_val_q)) ? kern_q : best_idx_q;
    assign out_class = out_last ? class_sel : '0;

`ifdef NN_SAT_EN
    assign out_score = OUT_W'(nn_saturate(64'(acc), OUT_W));
`else
    assign out_score = acc[OUT_W-1:0];
`endif

endmodule

// File: tb/tb_nn_kernel_classifier.sv
// Randomised and directed bench for nn_kernel_classifier against a dot-product
// reference model kept in the bench.
module tb_nn_kernel_classifier;

    localparam int NPIX  = 9;
    localparam int PIX_W = 8;
    localparam int NKERN = 4;
    localparam int OUT_W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        w_wr;
    logic [1:0]  w_kern;
    logic [3:0]  w_pix;
    logic [7:0]  w_data;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] in_image;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_score;
    logic [1:0]  out_kern;
    logic        out_last;
    logic [1:0]  out_class;

    always #5 clk = ~clk;

    nn_kernel_classifier #(
        .NPIX  (NPIX),
        .PIX_W (PIX_W),
        .NKERN (NKERN),
        .OUT_W (OUT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .w_wr      (w_wr),
        .w_kern    (w_kern),
        .w_pix     (w_pix),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_image  (in_image),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_score (out_score),
        .out_kern  (out_kern),
        .out_last  (out_last),
        .out_class (out_class)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int score;
        int kern;
        bit last;
        int cls;
    } beat_t;

    int    mw [NKERN][NPIX];
    beat_t exp_q[$];
    beat_t log_q[$];
    int    mac_left = 0;

    function automatic int to_score(input int acc);
        int v;
        v = acc;
`ifdef NN_SAT_EN
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
`endif
        return v & 255;
    endfunction

    function automatic void make_beats(input logic [71:0] img);
        int acc [NKERN];
        int best;
        int px;
        best = 0;
        for (int k = 0; k < NKERN; k++) begin
            acc[k] = 0;
            for (int p = 0; p < NPIX; p++) begin
                px = $signed(img[p*PIX_W +: PIX_W]);
                acc[k] += px * mw[k][p];
            end
            if (acc[k] > acc[best]) best = k;
        end
        for (int k = 0; k < NKERN; k++) begin
            exp_q.push_back('{score: to_score(acc[k]), kern: k, last: (k == NKERN-1),
                              cls: (k == NKERN-1) ? best : 0});
        end
    endfunction

    always @(negedge clk) begin : cmp
        bit    idle;
        bit    exp_valid;
        beat_t b;
        if (!rst_n) begin
            exp_q.delete();
            mac_left = 0;
            for (int k = 0; k < NKERN; k++)
                for (int p = 0; p < NPIX; p++)
                    mw[k][p] = 0;
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
        end else begin
            idle      = (exp_q.size() == 0);
            exp_valid = !idle && (mac_left == 0);
            chk("in_ready", 32'(in_ready), 32'(idle));
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("out_score", 32'(out_score), 32'(exp_q[0].score));
                chk("out_kern", 32'(out_kern), 32'(exp_q[0].kern));
                chk("out_last", 32'(out_last), 32'(exp_q[0].last));
                chk("out_class", 32'(out_class), 32'(exp_q[0].cls));
            end else begin
                chk("idle_out_last", 32'(out_last), 32'd0);
                chk("idle_out_class", 32'(out_class), 32'd0);
            end
            if (mac_left > 0) mac_left--;
            if (exp_valid && out_ready) begin
                b = exp_q.pop_front();
                log_q.push_back('{score: int'(out_score), kern: int'(out_kern),
                                  last: out_last, cls: int'(out_class)});
                if (!b.last) mac_left = NPIX;
            end
            if (idle) begin
                if (w_wr && (w_pix < 4'(NPIX))) mw[w_kern][w_pix] = int'($signed(w_data));
                if (in_valid) begin
                    make_beats(in_image);
                    mac_left = NPIX;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int k, input int p, input logic [7:0] d);
        w_wr   = 1'b1;
        w_kern = 2'(k);
        w_pix  = 4'(p);
        w_data = d;
        step();
        w_wr = 1'b0;
    endtask

    task automatic load_kernel(input int k, input logic [71:0] kv);
        for (int p = 0; p < NPIX; p++) write_w(k, p, kv[p*8 +: 8]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 500) begin
            step();
            n++;
        end
        chk("wait_idle", 32'(in_ready), 32'd1);
    endtask

    task automatic send_image(input logic [71:0] img);
        wait_idle();
        in_valid = 1'b1;
        in_image = img;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_beats(input int base, input int n);
        int c;
        c = 0;
        while (log_q.size() < base + n && c < 500) begin
            step();
            c++;
        end
        chk("beats_received", 32'(log_q.size() - base), 32'(n));
    endtask

    function automatic logic [71:0] alt(input logic [7:0] a, input logic [7:0] b);
        logic [71:0] v;
        for (int p = 0; p < NPIX; p++) v[p*8 +: 8] = (p % 2 == 0) ? a : b;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int          base;
        int          c;
        logic [71:0] pat;
        logic [7:0]  sat_exp;

        rst_n     = 1'b0;
        w_wr      = 1'b0;
        w_kern    = '0;
        w_pix     = '0;
        w_data    = '0;
        in_valid  = 1'b0;
        in_image  = '0;
        out_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_score", 32'(out_score), 32'd0);
        chk("reset_out_class", 32'(out_class), 32'd0);
        chk("reset_out_kern", 32'(out_kern), 32'd0);

        // Opposite-sign kernels: +9 and -9 against the k0 pattern.
        pat = alt(8'h01, 8'hFF);
        load_kernel(0, pat);
        load_kernel(1, alt(8'hFF, 8'h01));
        base = log_q.size();
        send_image(pat);
        wait_beats(base, 4);
        if (log_q.size() >= base + 4) begin
            chk("pat_score0", 32'(log_q[base].score), 32'h09);
            chk("pat_score1", 32'(log_q[base+1].score), 32'hF7);
            chk("pat_score2", 32'(log_q[base+2].score), 32'h00);
            chk("pat_score3", 32'(log_q[base+3].score), 32'h00);
            chk("pat_class", 32'(log_q[base+3].cls), 32'd0);
            chk("pat_last", 32'(log_q[base+3].last), 32'd1);
        end

        // Large positive sum: clamps or wraps depending on build.
        wait_idle();
        for (int k = 0; k < NKERN; k++) load_kernel(k, alt(8'h7F, 8'h7F));
        base = log_q.size();
        send_image(alt(8'h7F, 8'h7F));
        wait_beats(base, 4);
`ifdef NN_SAT_EN
        sat_exp = 8'h7F;
`else
        sat_exp = 8'h09;
`endif
        if (log_q.size() >= base + 4) begin
            chk("big_score0", 32'(log_q[base].score), 32'(sat_exp));
            chk("big_score3", 32'(log_q[base+3].score), 32'(sat_exp));
            chk("big_class", 32'(log_q[base+3].cls), 32'd0);
        end

        // Tie between k0 and k1 resolves to the lower index.
        wait_idle();
        load_kernel(0, pat);
        load_kernel(1, pat);
        load_kernel(2, '0);
        load_kernel(3, '0);
        base = log_q.size();
        send_image(pat);
        wait_beats(base, 4);
        if (log_q.size() >= base + 4) begin
            chk("tie_score0", 32'(log_q[base].score), 32'h09);
            chk("tie_score1", 32'(log_q[base+1].score), 32'h09);
            chk("tie_class", 32'(log_q[base+3].cls), 32'd0);
        end

        // Hold beat 1 for five cycles.
        base = log_q.size();
        send_image(pat);
        c = 0;
        while (!(out_valid && out_kern == 2'd1) && c < 200) begin
            step();
            c++;
        end
        out_ready = 1'b0;
        repeat (5) begin
            step();
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_kern", 32'(out_kern), 32'd1);
            chk("stall_score", 32'(out_score), 32'h09);
        end
        out_ready = 1'b1;
        wait_beats(base, 4);
        if (log_q.size() >= base + 4) begin
            for (int k = 0; k < NKERN; k++) chk("stall_seq_kern", 32'(log_q[base+k].kern), 32'(k));
        end

        // Weight write during MAC must not land.
        base = log_q.size();
        send_image(pat);
        step();
        step();
        w_wr   = 1'b1;
        w_kern = 2'd0;
        w_pix  = 4'd0;
        w_data = 8'h40;
        step();
        w_wr = 1'b0;
        wait_beats(base, 4);
        base = log_q.size();
        send_image(pat);
        wait_beats(base, 4);
        if (log_q.size() >= base + 4) begin
            chk("busywr_score0", 32'(log_q[base].score), 32'h09);
            chk("busywr_score1", 32'(log_q[base+1].score), 32'h09);
            chk("busywr_class", 32'(log_q[base+3].cls), 32'd0);
        end

        // Random traffic: writes, images and back-pressure on every cycle.
        wait_idle();
        repeat (2500) begin
            w_wr      = ($urandom_range(0, 2) == 0);
            w_kern    = 2'($urandom);
            w_pix     = 4'($urandom);
            w_data    = 8'($urandom);
            in_valid  = ($urandom_range(0, 3) == 0);
            in_image  = {8'($urandom), 32'($urandom), 32'($urandom)};
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        w_wr      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Reset in the middle of MAC drops the image and clears the weights.
        for (int k = 0; k < NKERN; k++) load_kernel(k, alt(8'h03, 8'hFD));
        send_image(alt(8'h01, 8'h01));
        repeat (3) step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        base = log_q.size();
        send_image(alt(8'h01, 8'h01));
        wait_beats(base, 4);
        if (log_q.size() >= base + 4) begin
            for (int k = 0; k < NKERN; k++) chk("post_rst_score", 32'(log_q[base+k].score), 32'h00);
            chk("post_rst_class", 32'(log_q[base+3].cls), 32'd0);
        end

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
